// File: rtl/addsub_div_sequencer.sv
// Unsigned restoring divider sequencing a shared adder_substractor.
// One subtract-mode trial per RUN cycle, WIDTH cycles per result.
module addsub_div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] as_a,
    output logic [WIDTH-1:0] as_b,
    output logic             as_subs,
    input  logic [WIDTH-1:0] as_s,
    input  logic             as_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dbz
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] d_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;

    logic [WIDTH-1:0] trial;
    logic             msb_out;
    logic             accept;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] q_d;
    logic             in_run;
    logic             last_iter;

    // One restoring step: shift in next dividend bit, keep difference if it fits
    always_comb begin
        trial     = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
        msb_out   = r_q[WIDTH-1];
        accept    = msb_out | as_cout;
        r_d       = accept ? as_s : trial;
        q_d       = {q_q[WIDTH-2:0], accept};
        in_run    = (state_q == S_RUN);
        last_iter = (cnt_q == CW'(WIDTH - 1));
    end

    // Shared adder is only driven while iterating; zeros keep it quiet otherwise
    always_comb begin
        as_a    = in_run ? trial : '0;
        as_b    = in_run ? d_q : '0;
        as_subs = in_run;
    end

    // Control FSM with working registers and held results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        busy_q <= 1'b1;
                        if (divisor == '0) begin
                            quot_q  <= '1;
                            rem_q   <= dividend;
                            dbz_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            d_q     <= divisor;
                            q_q     <= dividend;
                            r_q     <= '0;
                            cnt_q   <= '0;
                            dbz_q   <= 1'b0;
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_q   <= r_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_iter) begin
                        quot_q  <= q_d;
                        rem_q   <= r_d;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Results and status come straight from registers
    always_comb begin
        busy      = busy_q;
        done      = done_q;
        quotient  = quot_q;
        remainder = rem_q;
        dbz       = dbz_q;
    end

endmodule

// File: tb/tb_addsub_div_sequencer.sv
// Randomised and directed bench for addsub_div_sequencer.
// Includes a behavioural adder_substractor and a plain-arithmetic reference.
module tb_addsub_div_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] as_a;
    logic [W-1:0] as_b;
    logic         as_subs;
    logic [W-1:0] as_s;
    logic         as_cout;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         dbz;

    int n_cmp = 0;
    int n_bad = 0;

    addsub_div_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .as_a      (as_a),
        .as_b      (as_b),
        .as_subs   (as_subs),
        .as_s      (as_s),
        .as_cout   (as_cout),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz)
    );

    always #5 clk = ~clk;

    // External adder: Cout=1 means no borrow in subtract mode
    logic [W:0] sum;
    always_comb begin
        sum = '0;
        if (as_subs)
            sum = {1'b0, as_a} + {1'b0, ~as_b} + {{W{1'b0}}, 1'b1};
        else
            sum = {1'b0, as_a} + {1'b0, as_b};
        as_s    = sum[W-1:0];
        as_cout = sum[W];
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one division and check result, latency, busy and adder control
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit poke);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        int           n;
        int           nbusy;
        int           nsubs;
        int           lat;
        if (b == 0) begin
            eq  = '1;
            er  = a;
            lat = 1;
        end else begin
            eq  = a / b;
            er  = a % b;
            lat = W + 1;
        end
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        n     = 1;
        nbusy = 0;
        nsubs = 0;
        while (!done && n < 200) begin
            if (busy) nbusy++;
            if (as_subs) nsubs++;
            start = poke && (n == 3);
            if (start) begin
                dividend = 50;
                divisor  = 5;
            end
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b0;
        chk("latency", n, lat);
        chk("busy_run", nbusy, n - 1);
        chk("subs_run", nsubs, (b == 0) ? 0 : n - 1);
        chk("busy_done", busy, 1);
        chk("subs_done", as_subs, 0);
        chk("quotient", quotient, eq);
        chk("remainder", remainder, er);
        chk("dbz", dbz, (b == 0));
        if (poke) begin
            start    = 1'b1;
            dividend = 50;
            divisor  = 5;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("done_pulse", done, 0);
        chk("busy_idle", busy, 0);
        if (poke) begin
            @(posedge clk);
            #1;
            chk("ignored_busy", busy, 0);
            chk("ignored_q", quotient, eq);
            chk("ignored_r", remainder, er);
        end
        chk("subs_idle", as_subs, 0);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           saw_done;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_dbz", dbz, 0);
        chk("rst_subs", as_subs, 0);
        @(negedge clk);
        rst = 1'b0;

        run_op(32'd100, 32'd7, 1'b0);
        run_op(32'h0000_1234, 32'd0, 1'b0);
        run_op(32'd9, 32'd3, 1'b0);
        run_op(32'hFFFF_FFFF, 32'h8000_0001, 1'b0);
        run_op(32'd5, 32'd9, 1'b0);
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0);
        run_op(32'd0, 32'd5, 1'b0);
        run_op(32'd100, 32'd7, 1'b1);

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 4))
                0: rb = 0;
                1: rb = $urandom_range(1, 15);
                2: rb = $urandom & 32'h0000_FFFF;
                3: rb = $urandom | 32'h8000_0000;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) ra = ra >> $urandom_range(0, 31);
            run_op(ra, rb, 1'b0);
        end

        run_op(32'd100, 32'd7, 1'b0);
        @(negedge clk);
        start    = 1'b1;
        dividend = 100;
        divisor  = 7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_q", quotient, 0);
        chk("abort_r", remainder, 0);
        chk("abort_dbz", dbz, 0);
        chk("abort_subs", as_subs, 0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) saw_done++;
        end
        chk("abort_quiet", saw_done, 0);
        run_op(32'd20, 32'd6, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/addsub_div_sequencer.md
Name: addsub_div_sequencer

Overview:
- Multi-cycle unsigned restoring-division controller that time-multiplexes one external adder_substractor instance, running it in subtract mode once per cycle.
- It owns the partial remainder, quotient and iteration counter, and drives the shared adder's A, B and SUBS inputs.
- It sits beside the ALU datapath and serves DIV/MOD operations with a start/busy/done handshake.

Parameters:
WIDTH, 32, operand/result width; must match the connected adder_substractor WIDTH (>=2).

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
dividend  input  WIDTH  numerator, captured when start is accepted
divisor  input  WIDTH  denominator, captured when start is accepted
as_a  output  WIDTH  to adder_substractor A
as_b  output  WIDTH  to adder_substractor B
as_subs  output  1  to adder_substractor SUBS
as_s  input  WIDTH  from adder_substractor S
as_cout  input  1  from adder_substractor Cout (1 = no borrow when SUBS=1)
busy  output  1  high in RUN and DONE
done  output  1  one-cycle completion pulse
quotient  output  WIDTH  result, held until the next accepted start
remainder  output  WIDTH  result, held until the next accepted start
dbz  output  1  divide-by-zero flag for the held result

Behaviour:
- Clock and reset: one clock domain (clk). rst is asynchronous and active-high.
- Reset state: state=IDLE; busy, done, dbz = 0; quotient, remainder, internal R/Q/D/count = 0.
- Reset mid-operation aborts immediately with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 and divisor!=0: D<=divisor, Q<=dividend, R<=0, count<=0, go to RUN.
  - start=1 and divisor==0: quotient<={WIDTH{1}}, remainder<=dividend, dbz<=1, go to DONE.
  - dbz is cleared on any accepted start with divisor!=0.
- RUN, one iteration per cycle:
  - trial = {R[WIDTH-2:0], Q[WIDTH-1]}; msb_out = R[WIDTH-1].
  - Drive as_a=trial, as_b=D, as_subs=1 (combinational from registers).
  - accept = msb_out | as_cout.
  - On the edge: R <= accept ? as_s : trial; Q <= {Q[WIDTH-2:0], accept}; count++.
  - The msb_out term covers the WIDTH+1-bit shifted remainder. as_s is then correct mod 2^WIDTH because the true difference is < D.
  - When count==WIDTH-1 on the edge: quotient<=next Q, remainder<=next R, go to DONE.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE. start in DONE is ignored.
- Outside RUN: as_subs=0, as_a=0, as_b=0, so the adder is free and idle-safe.
- start while busy is ignored; operand changes after acceptance have no effect.
- Latency:
  - Normal: done is high in the cycle after WIDTH+1 rising edges from the edge that accepted start (WIDTH RUN cycles + 1 DONE).
  - Divide-by-zero: done on the very next cycle (1 edge).
- Throughput: a new start is accepted in the IDLE cycle after DONE, giving a minimum spacing of WIDTH+2 cycles.
- Arithmetic: unsigned only. Results satisfy dividend = quotient*divisor + remainder, with remainder < divisor. The adder's N/Z/V outputs are unused.
- Counter width: $clog2(WIDTH)+1 bits. No wrap-around is possible because the count is reset on every accept.

Test Plan:
1. WIDTH=32, start with dividend=100, divisor=7 -> done after 33 edges; quotient=14, remainder=2, dbz=0; busy high for 33 cycles.
2. dividend=0x0000_1234, divisor=0 -> done on the next cycle; quotient=0xFFFF_FFFF, remainder=0x0000_1234, dbz=1. A following 9/3 -> quotient=3, remainder=0, dbz=0.
3. dividend=0xFFFF_FFFF, divisor=0x8000_0001 -> quotient=1, remainder=0x7FFF_FFFE. This exercises the msb_out accept path.
4. Edge operands: 5/9 -> quotient=0, remainder=5; 0xFFFF_FFFF/1 -> quotient=0xFFFF_FFFF, remainder=0; 0/5 -> 0, 0.
5. Start 100/7, then pulse start with 50/5 at cycles 3 and 33 (DONE) -> second request ignored both times; result stays 14/2; as_subs low in IDLE/DONE.
6. Start 100/7, assert rst at cycle 10 for 1 cycle -> outputs immediately return to reset values with no done pulse. A new start 20/6 then gives quotient=3, remainder=2.
